// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory arbiter: FSM states, SPI opcodes,
// frame field sizes and the frame builder used at grant time.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_e;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    // Reads carry an all-zero data field so MOSI stays low while MISO is captured.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 we,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        return {(we ? OP_WRITE : OP_READ), addr, (we ? wdata : {DATA_BITS{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// Bit engine for one SPI frame: two-cycle bit timing, MOSI shift-out (MSB first)
// and MISO capture sampled at the close of the high phase.
module spi_word_shifter
    import spi_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic                  shift_en_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  bit_end_o,
    output logic [CNT_W-1:0]      bit_cnt_o,
    output logic [DATA_BITS-1:0]  rx_next_o
);

    logic                  phase_q, phase_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-2:0]  rx_q, rx_d;

    assign rx_next_o = {rx_q, miso_i};
    assign sclk_o    = phase_q;
    assign mosi_o    = tx_q[FRAME_BITS-1];
    assign bit_end_o = shift_en_i & phase_q;
    assign bit_cnt_o = cnt_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        phase_d = phase_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        if (load_i) begin
            phase_d = 1'b0;
            cnt_d   = '0;
            tx_d    = frame_i;
            rx_d    = '0;
        end else if (shift_en_i) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                cnt_d = cnt_q + CNT_W'(1);
                tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
                rx_d  = rx_next_o[DATA_BITS-2:0];
            end
        end else begin
            phase_d = 1'b0;
            cnt_d   = '0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-requester arbiter in front of a serial SPI memory: alternating grant on ties,
// one 48-bit read/write frame per grant, one-cycle ack to the winner.
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              spi_select,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;

    logic                  win;
    logic                  load;
    logic                  shift_en;
    logic                  bit_end;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  rx_next;
    logic [FRAME_BITS-1:0] frame;

    // On a tie the requester not served last wins; a lone request always wins.
    assign win   = (req0 && req1) ? ~last_q : req1;
    assign frame = build_frame(win ? we1 : we0,
                               ADDR_BITS'(win ? addr1 : addr0),
                               DATA_BITS'(win ? wdata1 : wdata0));

    spi_word_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .frame_i    (frame),
        .shift_en_i (shift_en),
        .miso_i     (spi_miso),
        .sclk_o     (spi_clk),
        .mosi_o     (spi_mosi),
        .bit_end_o  (bit_end),
        .bit_cnt_o  (bit_cnt),
        .rx_next_o  (rx_next)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = CMD;
                    gnt_d   = win;
                    last_d  = win;
                    we_d    = win ? we1 : we0;
                    load    = 1'b1;
                end
            end
            CMD: begin
                shift_en = 1'b1;
                if (bit_end && bit_cnt == CNT_W'(CMD_BITS - 1)) state_d = ADDR;
            end
            ADDR: begin
                shift_en = 1'b1;
                if (bit_end && bit_cnt == CNT_W'(CMD_BITS + ADDR_BITS - 1)) state_d = DATA;
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_end && bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = rx_next;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign spi_select = !(state_q inside {CMD, ADDR, DATA});
    assign ack0       = (state_q == DONE) && !gnt_q;
    assign ack1       = (state_q == DONE) &&  gnt_q;
    assign rdata      = DATA_W'(rdata_q);

endmodule
